inst_fetch_unit: RTL and testbench

Instruction fetch front end that produces the 32-bit instruction words consumed by the instruction decoder. Drives a pipelined instruction-memory port (address phase with grant, in-order data phase), buffers returned words with their PCs in a small FIFO, and presents them to the decoder through a valid/ready handshake. A taken branch or jump, signalled by the decoder's `pc_src` together with the datapath-computed target, flushes the buffer, discards in-flight responses and restarts fetch at the target.

---
 rtl/inst_fetch_unit.sv | 219 +++++++++++++++++++++
 tb/tb_inst_fetch_unit.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//
// Instruction fetch front end. Issues word-aligned fetches on a pipelined
// instruction-memory port (address phase with grant, in-order data phase),
// buffers returned words together with their PCs in a small FIFO and hands
// them to the decoder over a valid/ready handshake. A taken branch/jump
// (decoder pc_src, accepted together with the instruction it belongs to)
// flushes the FIFO, marks every in-flight response for discard and restarts
// fetch at the target.
//
// Optional feature macro: FETCH_BYPASS_EN
//   defined   : a kept response arriving while the FIFO is empty is presented
//               on inst/inst_pc/inst_valid in the same cycle; if accepted it
//               is never written to the FIFO.
//   undefined : every word goes through the FIFO; inst, inst_pc and
//               inst_valid come straight from registers.
//
// Parameters
//   DEPTH       FIFO entries and maximum outstanding requests (power of 2, >= 2)
//   RESET_PC    first fetch address after reset
//
// Ports
//   clk, rst_n            clock (rising edge), async active-low reset
//   imem_req/imem_addr    address-phase request and word-aligned address
//   imem_gnt              address accepted when imem_req && imem_gnt
//   imem_rvalid/rdata     in-order data phase, one pulse per granted request
//   inst/inst_pc          instruction at the FIFO head and its PC
//   inst_valid/inst_ready decoder handshake; head consumed when both high
//   redirect/redirect_pc  taken branch/jump and its target (bits [1:0] ignored)
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH + 1);   // counters span 0..DEPTH
    localparam int PW = $clog2(DEPTH);       // PC-queue pointers

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [31:0]   fetch_pc;
    logic          started;
    logic [CW-1:0] count;         // words held in the FIFO
    logic [CW-1:0] outstanding;   // granted, data not yet returned
    logic [CW-1:0] discard;       // in-flight responses still to be dropped
    logic          head_valid;    // registered copy of (count != 0)

    // Shift-style FIFO: entry 0 is always the head, so the head drives the
    // outputs directly from flops.
    logic [31:0] fifo_pc   [DEPTH];
    logic [31:0] fifo_inst [DEPTH];

    // PCs of granted requests, consumed in order as responses come back
    // (dropped responses consume their entry too).
    logic [31:0]   pcq [DEPTH];
    logic [PW-1:0] pcq_wr;
    logic [PW-1:0] pcq_rd;

    // -------------------------------------------------------------------------
    // Per-cycle events
    // -------------------------------------------------------------------------
    logic          grant;
    logic          resp_fire;
    logic          resp_keep;
    logic          bypass_hit;
    logic          bypass_take;
    logic          fifo_pop;
    logic          fifo_push;
    logic          redirect_taken;
    logic [CW:0]   inflight_total;
    logic [CW-1:0] count_after_pop;
    logic [CW-1:0] count_next;
    logic [CW-1:0] outstanding_next;
    logic [31:0]   fifo_pc_next   [DEPTH];
    logic [31:0]   fifo_inst_next [DEPTH];
    logic          unused_redirect_lsbs;

    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // A response with nothing outstanding is a protocol error; it is ignored.
    assign resp_fire = imem_rvalid && (outstanding != '0);
    assign resp_keep = resp_fire && (discard == '0);

`ifdef FETCH_BYPASS_EN
    assign bypass_hit = resp_keep && !head_valid;
    assign inst_valid = head_valid || bypass_hit;
    assign inst       = bypass_hit ? imem_rdata  : fifo_inst[0];
    assign inst_pc    = bypass_hit ? pcq[pcq_rd] : fifo_pc[0];
`else
    assign bypass_hit = 1'b0;
    assign inst_valid = head_valid;
    assign inst       = fifo_inst[0];
    assign inst_pc    = fifo_pc[0];
`endif

    assign bypass_take    = bypass_hit && inst_ready;
    assign fifo_pop       = head_valid && inst_ready;
    assign redirect_taken = redirect && inst_valid && inst_ready;

    // Only issue when a FIFO slot is guaranteed for the returning word.
    assign inflight_total = {1'b0, count} + {1'b0, outstanding};
    assign imem_req  = started && !redirect_taken &&
                       (inflight_total < (CW + 1)'(DEPTH));
    assign imem_addr = fetch_pc;
    assign grant     = imem_req && imem_gnt;

    // A response arriving with a taken redirect is dropped, unless it is the
    // bypassed word that the redirect itself consumes.
    assign fifo_push        = resp_keep && !bypass_take && !redirect_taken;
    assign count_after_pop  = count - CW'(fifo_pop);
    assign count_next       = redirect_taken ? '0 : count_after_pop + CW'(fifo_push);
    assign outstanding_next = outstanding + CW'(grant) - CW'(resp_fire);

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            fifo_pc_next[i]   = fifo_pc[i];
            fifo_inst_next[i] = fifo_inst[i];
        end
        if (fifo_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                fifo_pc_next[i]   = fifo_pc[i + 1];
                fifo_inst_next[i] = fifo_inst[i + 1];
            end
        end
        if (fifo_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == count_after_pop) begin
                    fifo_pc_next[i]   = pcq[pcq_rd];
                    fifo_inst_next[i] = imem_rdata;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC;
            started     <= 1'b0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            head_valid  <= 1'b0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= '0;
                fifo_inst[i] <= '0;
            end
        end else begin
            started <= 1'b1;

            if (redirect_taken) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (grant) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (grant) begin
                pcq_wr <= pcq_wr + PW'(1);
            end
            if (resp_fire) begin
                pcq_rd <= pcq_rd + PW'(1);
            end

            count       <= count_next;
            head_valid  <= (count_next != '0);
            outstanding <= outstanding_next;

            // Everything still in flight after this cycle belongs to the old
            // path; no grant can occur in the redirect cycle.
            if (redirect_taken) begin
                discard <= outstanding_next;
            end else if (resp_fire && (discard != '0)) begin
                discard <= discard - CW'(1);
            end

            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc[i]   <= fifo_pc_next[i];
                fifo_inst[i] <= fifo_inst_next[i];
            end
        end
    end

    // NOTE: the PC queue is plain storage with no reset; an entry is only
    // read after its grant has written it, so its power-up value is never seen.
    always_ff @(posedge clk) begin
        if (grant) begin
            pcq[pcq_wr] <= fetch_pc;
        end
    end

    a_no_stray_rvalid : assert property (
        @(posedge clk) disable iff (!rst_n) imem_rvalid |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//
// Self-checking bench for inst_fetch_unit (DEPTH = 2, RESET_PC = 0x100).
// A memory model grants requests and returns addr ^ 0xA5A5_0000 in order,
// one cycle after grant unless held. Directed phases push the PCs they expect
// the decoder to see into a queue; an independent monitor pops and compares
// on every accepted instruction. Fetch timing is checked directly by the
// phases themselves.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] XOR_KEY  = 32'hA5A5_0000;
`ifdef FETCH_BYPASS_EN
    localparam int FILL_LAT = 1;
`else
    localparam int FILL_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        redirect;
    logic [31:0] redirect_pc;

    inst_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int first_valid_cyc = -1;
    logic mem_hold  = 1'b0;

    typedef struct {
        int          gcyc;
        logic [31:0] addr;
    } mem_req_t;

    mem_req_t    pend[$];
    logic [31:0] gnt_log[$];
    int          gnt_cyc_log[$];
    int          rvalid_cyc_log[$];
    logic [31:0] exp_pc[$];
    logic [31:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    function automatic logic [31:0] gnt_at(input int i);
        if (i < gnt_log.size()) return gnt_log[i];
        return 'x;
    endfunction

    // ---------------- memory model ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            pend.delete();
        end else if (imem_req && imem_gnt) begin
            pend.push_back('{gcyc: cyc, addr: imem_addr});
            gnt_log.push_back(imem_addr);
            gnt_cyc_log.push_back(cyc);
        end
    end

    always @(posedge clk) begin
        #1;
        cyc++;
        if (rst_n && !mem_hold && pend.size() > 0 && cyc > pend[0].gcyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = pend[0].addr ^ XOR_KEY;
            rvalid_cyc_log.push_back(cyc);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_pc.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_inst: got pc %h inst %h, none expected", inst_pc, inst);
            end else begin
                mon_exp = exp_pc.pop_front();
                check("inst_pc", inst_pc, mon_exp);
                check("inst", inst, mon_exp ^ XOR_KEY);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_pc.push_back(base + 32'(4 * i));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_pc.delete();
        gnt_log.delete();
        gnt_cyc_log.delete();
        rvalid_cyc_log.delete();
        first_valid_cyc = -1;
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Waits until every expected word was delivered, then stops consuming.
    task automatic wait_drained(input string name, input int budget);
        int n = 0;
        while (exp_pc.size() != 0 && n < budget) begin
            sample();
            n++;
        end
        vectors++;
        if (exp_pc.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d words still expected after %0d cycles", name, exp_pc.size(), budget);
        end
        tick();
        inst_ready = 1'b0;
    endtask

    task automatic wait_grants(input string name, input int n_gnt, input int budget);
        int n = 0;
        while (gnt_log.size() < n_gnt && n < budget) begin
            sample();
            n++;
        end
        check(name, 32'(gnt_log.size()), 32'(n_gnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed phases ----------------
    initial begin
        rst_n = 1'b0; imem_gnt = 1'b1; inst_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;

        // Reset values
        repeat (3) @(posedge clk);
        sample();
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_inst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_inst_pc", inst_pc, 32'd0);

        // Streaming: 16 instructions from RESET_PC
        push_exp(RESET_PC, 16);
        inst_ready = 1'b1;
        rst_n = 1'b1;
        #1 check("req_before_start_edge", 32'(imem_req), 32'd0);
        sample();
        check("req_after_start_edge", 32'(imem_req), 32'd1);
        check("first_imem_addr", imem_addr, RESET_PC);
        wait_drained("stream_16", 200);
        check("grant0_addr", gnt_at(0), 32'h0000_0100);
        check("grant1_addr", gnt_at(1), 32'h0000_0104);
        check("grant2_addr", gnt_at(2), 32'h0000_0108);
        if (gnt_cyc_log.size() > 0 && rvalid_cyc_log.size() > 0) begin
            check("lat_grant_to_valid", 32'(first_valid_cyc - gnt_cyc_log[0]), 32'(FILL_LAT));
            check("lat_rvalid_to_valid", 32'(first_valid_cyc - rvalid_cyc_log[0]), 32'(FILL_LAT - 1));
        end else begin
            check("lat_logs_present", 32'd0, 32'd1);
        end

        // Backpressure: two grants, then fetch stalls with the FIFO full
        do_reset();
        repeat (8) sample();
        check("bp_grant_count", 32'(gnt_log.size()), 32'd2);
        check("bp_req_low", 32'(imem_req), 32'd0);
        check("bp_head_valid", 32'(inst_valid), 32'd1);
        check("bp_head_pc", inst_pc, 32'h0000_0100);
        push_exp(RESET_PC, 6);
        tick();
        inst_ready = 1'b1;
        wait_grants("bp_resume_grants", 3, 20);
        check("bp_resume_addr", gnt_at(2), 32'h0000_0108);
        wait_drained("bp_drain", 100);

        // Redirect with one buffered word and one response in flight
        mem_hold = 1'b1;
        do_reset();
        repeat (5) sample();
        check("rd_grants_before", 32'(gnt_log.size()), 32'd2);
        push_exp(RESET_PC, 1);
        mem_hold = 1'b0;             // release exactly one response
        sample();
        mem_hold = 1'b1;
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_2002;   // not consuming: no effect
        sample();
        check("rd_ignored_head_pc", inst_pc, 32'h0000_0100);
        tick();
        inst_ready = 1'b1;
        sample();
        check("rd_req_low_in_R", 32'(imem_req), 32'd0);
        exp_pc.delete();
        push_exp(32'h0000_2000, 4);
        tick();
        redirect = 1'b0;
        sample();
        check("rd_req_in_R1", 32'(imem_req), 32'd1);
        check("rd_addr_in_R1", imem_addr, 32'h0000_2000);
        check("rd_fifo_empty_R1", 32'(inst_valid), 32'd0);
        mem_hold = 1'b0;
        wait_drained("rd_drain", 100);

        // Redirect coincident with imem_rvalid
        mem_hold = 1'b1;
        do_reset();
        repeat (5) sample();
        push_exp(RESET_PC, 1);
        mem_hold = 1'b0;
        tick();                      // 0x100 returns
        tick();                      // 0x104 returns while 0x100 is the head
        redirect = 1'b1; redirect_pc = 32'h0000_3000; inst_ready = 1'b1;
        sample();
        check("rc_req_low_in_R", 32'(imem_req), 32'd0);
        exp_pc.delete();
        push_exp(32'h0000_3000, 4);
        tick();
        redirect = 1'b0;
        sample();
        check("rc_fifo_empty_R1", 32'(inst_valid), 32'd0);
        check("rc_req_in_R1", 32'(imem_req), 32'd1);
        check("rc_addr_in_R1", imem_addr, 32'h0000_3000);
        wait_drained("rc_drain", 100);

        // Reset asserted mid-stream with one buffered, one outstanding
        mem_hold = 1'b1;
        do_reset();
        repeat (5) sample();
        mem_hold = 1'b0;
        sample();
        mem_hold = 1'b1;
        sample();
        check("mr_pre_valid", 32'(inst_valid), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mr_inst_valid_low", 32'(inst_valid), 32'd0);
        check("mr_req_low", 32'(imem_req), 32'd0);
        check("mr_addr_reset", imem_addr, RESET_PC);
        mem_hold = 1'b0;
        do_reset();
        push_exp(RESET_PC, 4);
        inst_ready = 1'b1;
        wait_drained("mr_restart", 100);
        check("mr_restart_addr", gnt_at(0), RESET_PC);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
